// File: rtl/peak_packer.sv
// ---------------------------------------------------------------------------
// peak_packer
//
// Purpose:
//   Tracks the running peak of each drum-pad channel over a fixed frame period.
//   At every period boundary it packs all peaks into one 256-bit word for the
//   OSC/UDP framer. The word is held on a valid/ready output until the framer
//   accepts it.
//
// Ports:
//   aclk           - system clock; all logic runs on the rising edge
//   areset         - synchronous, active-high reset
//   s_axis_tdata   - unsigned 16-bit sample magnitude
//   s_axis_tuser   - channel ID of the sample
//   s_axis_tvalid  - sample valid
//   s_axis_tready  - sample accept (low during reset, high otherwise)
//   m_axis_tdata   - peak snapshot; channel n is in bits [16n+15:16n]
//   m_axis_tvalid  - snapshot valid (output slot FULL)
//   m_axis_tready  - framer accept
//   overrun_count  - saturating count of boundaries lost to a full slot
// ---------------------------------------------------------------------------
module peak_packer #(
    parameter int NUM_CH        = 16,
    parameter int PERIOD_CYCLES = 125000
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [15:0]  s_axis_tdata,
    input  logic [3:0]   s_axis_tuser,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [255:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [15:0]  overrun_count
);

    localparam int                 CNT_W    = $clog2(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [15:0]      peakQ [NUM_CH];
    logic [15:0]      peakD [NUM_CH];
    logic [15:0]      merged [NUM_CH];
    logic [255:0]     dataQ, dataD;
    logic [255:0]     snapshot;
    logic [15:0]      overrunQ, overrunD;
    logic             readyQ;
    logic             tick;
    logic             accept;
    logic             slotFree;

    assign s_axis_tready = readyQ;
    assign m_axis_tvalid = (stateQ == ST_FULL);
    assign m_axis_tdata  = dataQ;
    assign overrun_count = overrunQ;

    // Fold the sample accepted this cycle into each channel's peak. IDs at or
    // above NUM_CH match no channel, so they are dropped without a separate
    // range check. The merged values feed both the snapshot and the peak
    // registers, so a sample landing on the tick cycle is not lost.
    always_comb begin
        tick     = (cntQ == CNT_LAST);
        accept   = s_axis_tvalid & readyQ;
        slotFree = (stateQ == ST_EMPTY) | m_axis_tready;
        snapshot = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            merged[ch] = peakQ[ch];
            if (accept && (s_axis_tuser == 4'(ch)) && (s_axis_tdata > peakQ[ch])) begin
                merged[ch] = s_axis_tdata;
            end
            snapshot[16*ch +: 16] = merged[ch];
        end
    end

    // Next-state logic: period counter, output slot FSM, peak clearing and
    // overrun counting. A tick only snapshots when the slot is empty or is
    // being emptied in the same cycle; otherwise the peaks keep accumulating
    // so the next snapshot spans several periods.
    always_comb begin
        cntD     = tick ? '0 : cntQ + CNT_W'(1);
        stateD   = stateQ;
        dataD    = dataQ;
        overrunD = overrunQ;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            peakD[ch] = merged[ch];
        end
        if (tick) begin
            if (slotFree) begin
                dataD  = snapshot;
                stateD = ST_FULL;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    peakD[ch] = '0;
                end
            end else if (overrunQ != 16'hFFFF) begin
                overrunD = overrunQ + 16'd1;
            end
        end else if ((stateQ == ST_FULL) && m_axis_tready) begin
            stateD = ST_EMPTY;
        end
    end

    // State registers; reset drops any pending snapshot and clears all peaks.
    always_ff @(posedge aclk) begin
        if (areset) begin
            stateQ   <= ST_EMPTY;
            cntQ     <= '0;
            dataQ    <= '0;
            overrunQ <= '0;
            readyQ   <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                peakQ[ch] <= '0;
            end
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            dataQ    <= dataD;
            overrunQ <= overrunD;
            readyQ   <= 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                peakQ[ch] <= peakD[ch];
            end
        end
    end

endmodule

// File: tb/tb_peak_packer.sv
// ---------------------------------------------------------------------------
// tb_peak_packer
//
// Purpose:
//   Self-checking bench for peak_packer with NUM_CH=8, PERIOD_CYCLES=16.
//   A table of per-period sample sets with hand-computed snapshots is applied
//   first. Hand-written sequences then cover backpressure/overrun, a ready
//   pulse on the tick and reset while the slot is full.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_peak_packer;

    logic         aclk;
    logic         areset;
    logic [15:0]  s_axis_tdata;
    logic [3:0]   s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [15:0]  overrun_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int               nSamp;
        logic [2:0][3:0]  ch;
        logic [2:0][15:0] val;
        logic             lastOnTick;
        logic [255:0]     expSnap;
    } periodVec_t;

    periodVec_t vecs[6];

    peak_packer #(
        .NUM_CH        (8),
        .PERIOD_CYCLES (16)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overrun_count (overrun_count)
    );

    // 10 ns clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Hard time limit so a broken DUT can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] time limit exceeded");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 ns after
    // the rising edge.
    task automatic stepCycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] ch, input logic [15:0] d);
        s_axis_tvalid = v;
        s_axis_tuser  = ch;
        s_axis_tdata  = d;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Snapshot values that later sequences expect the output to hold.
    logic [255:0] snapV5;
    logic [255:0] snapCh1;
    logic [255:0] snapCh2;
    logic [15:0]  aVals[3];

    initial begin
        // Each record is one frame period: up to three samples (sent in order
        // index 0,1,2 starting at cycle 2, or the last one on the tick cycle)
        // and the snapshot expected one cycle after that period's tick.
        vecs[0] = '{3, {4'd5, 4'd0, 4'd0}, {16'hABCD, 16'h0080, 16'h0100}, 1'b0,
                    (256'hABCD << 80) | 256'h0100};
        vecs[1] = '{0, {4'd0, 4'd0, 4'd0}, {16'h0, 16'h0, 16'h0}, 1'b0, 256'h0};
        vecs[2] = '{1, {4'd0, 4'd0, 4'd3}, {16'h0, 16'h0, 16'h1234}, 1'b1,
                    256'h1234 << 48};
        vecs[3] = '{0, {4'd0, 4'd0, 4'd0}, {16'h0, 16'h0, 16'h0}, 1'b0, 256'h0};
        vecs[4] = '{3, {4'd4, 4'd4, 4'd12}, {16'h8000, 16'h7FFF, 16'hFFFF}, 1'b0,
                    256'h8000 << 64};
        vecs[5] = '{3, {4'd6, 4'd7, 4'd7}, {16'h0001, 16'h00FF, 16'h00FF}, 1'b0,
                    (256'h0001 << 96) | (256'h00FF << 112)};
        snapV5  = (256'h0001 << 96) | (256'h00FF << 112);
        snapCh1 = 256'h0030 << 16;
        snapCh2 = 256'h0042 << 32;
        aVals   = '{16'h0010, 16'h0020, 16'h0030};

        // Reset state.
        areset        = 1'b1;
        m_axis_tready = 1'b1;
        applyStimulus(1'b0, 4'd0, 16'h0);
        repeat (3) stepCycle();
        checkOutput("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        checkOutput("rst_tdata", m_axis_tdata, 256'h0);
        checkOutput("rst_overrun", 256'(overrun_count), 256'(0));
        checkOutput("rst_s_tready", 256'(s_axis_tready), 256'(0));
        areset = 1'b0;

        // Table-driven periods with the framer always ready.
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 16; c++) begin
                applyStimulus(1'b0, 4'd0, 16'h0);
                for (int k = 0; k < vecs[i].nSamp; k++) begin
                    int sc;
                    sc = (vecs[i].lastOnTick && (k == vecs[i].nSamp - 1)) ? 15 : 2 + k;
                    if (sc == c) applyStimulus(1'b1, vecs[i].ch[k], vecs[i].val[k]);
                end
                if (c == 8) begin
                    checkOutput($sformatf("vec%0d_mid_tvalid", i), 256'(m_axis_tvalid), 256'(0));
                end
                stepCycle();
            end
            applyStimulus(1'b0, 4'd0, 16'h0);
            checkOutput($sformatf("vec%0d_tvalid", i), 256'(m_axis_tvalid), 256'(1));
            checkOutput($sformatf("vec%0d_snap", i), m_axis_tdata, vecs[i].expSnap);
        end
        checkOutput("table_overrun", 256'(overrun_count), 256'(0));

        // Backpressure for three ticks while ch1 keeps rising.
        m_axis_tready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 16; c++) begin
                if (c == 3) applyStimulus(1'b1, 4'd1, aVals[p]);
                else        applyStimulus(1'b0, 4'd0, 16'h0);
                checkOutput($sformatf("hold_p%0d_c%0d_tvalid", p, c), 256'(m_axis_tvalid), 256'(1));
                checkOutput($sformatf("hold_p%0d_c%0d_tdata", p, c), m_axis_tdata, snapV5);
                stepCycle();
            end
        end
        applyStimulus(1'b0, 4'd0, 16'h0);
        checkOutput("hold_end_tdata", m_axis_tdata, snapV5);
        checkOutput("hold_overrun", 256'(overrun_count), 256'(3));

        // Framer drains mid-period; the next snapshot covers all held periods.
        for (int c = 0; c < 16; c++) begin
            m_axis_tready = (c >= 4);
            if (c == 5) begin
                checkOutput("drain_tvalid", 256'(m_axis_tvalid), 256'(0));
                checkOutput("drain_tdata_hold", m_axis_tdata, snapV5);
            end
            stepCycle();
        end
        checkOutput("multi_tvalid", 256'(m_axis_tvalid), 256'(1));
        checkOutput("multi_snap", m_axis_tdata, snapCh1);
        checkOutput("multi_overrun", 256'(overrun_count), 256'(3));

        // Ready pulsed only on the tick cycle while the slot is full.
        for (int c = 0; c < 16; c++) begin
            m_axis_tready = (c == 15);
            if (c == 5) applyStimulus(1'b1, 4'd2, 16'h0042);
            else        applyStimulus(1'b0, 4'd0, 16'h0);
            if (c == 14) begin
                checkOutput("pulse_pre_tvalid", 256'(m_axis_tvalid), 256'(1));
                checkOutput("pulse_pre_tdata", m_axis_tdata, snapCh1);
            end
            stepCycle();
        end
        m_axis_tready = 1'b0;
        applyStimulus(1'b0, 4'd0, 16'h0);
        checkOutput("pulse_tvalid", 256'(m_axis_tvalid), 256'(1));
        checkOutput("pulse_snap", m_axis_tdata, snapCh2);
        checkOutput("pulse_overrun", 256'(overrun_count), 256'(3));

        // Reset while full with a peak accumulated on ch6.
        for (int c = 0; c < 6; c++) begin
            if (c == 3) applyStimulus(1'b1, 4'd6, 16'h0999);
            else        applyStimulus(1'b0, 4'd0, 16'h0);
            stepCycle();
        end
        applyStimulus(1'b0, 4'd0, 16'h0);
        areset = 1'b1;
        stepCycle();
        checkOutput("mrst_tvalid", 256'(m_axis_tvalid), 256'(0));
        checkOutput("mrst_overrun", 256'(overrun_count), 256'(0));
        checkOutput("mrst_s_tready", 256'(s_axis_tready), 256'(0));
        checkOutput("mrst_tdata", m_axis_tdata, 256'h0);
        areset        = 1'b0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 2) checkOutput("post_s_tready", 256'(s_axis_tready), 256'(1));
            stepCycle();
        end
        checkOutput("post_tvalid", 256'(m_axis_tvalid), 256'(1));
        checkOutput("post_snap", m_axis_tdata, 256'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/peak_packer.md
Name: peak_packer

Overview:
- Sits directly upstream of the OSC/UDP framer and feeds its 256-bit AXI-Stream input.
- Accepts a continuous stream of per-channel 16-bit drum-pad magnitudes, tagged with a channel ID.
- Tracks the peak value of each channel over a fixed frame period.
- At each period boundary, snapshots all peaks into one 256-bit word and holds it on a valid/ready output until the framer accepts it.

Parameters:
- NUM_CH, 16, number of active channels (1..16); channel IDs >= NUM_CH are discarded.
- PERIOD_CYCLES, 125000, aclk cycles per frame period (1 kHz at 125 MHz); minimum 2.

Ports:
- aclk  in  1  system clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  16  unsigned sample magnitude.
- s_axis_tuser  in  4  channel ID of the sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sample accept; 0 while areset is high and 1 otherwise.
- m_axis_tdata  out  256  peak snapshot; channel n occupies bits [16n+15:16n]; bits for unused channels (>= NUM_CH) are 0.
- m_axis_tvalid  out  1  snapshot valid.
- m_axis_tready  in  1  framer accept.
- overrun_count  out  16  saturating count of period boundaries lost because the output slot was still full.

Behaviour:
- Reset values (areset sampled high at a clock edge): m_axis_tdata=0, m_axis_tvalid=0, overrun_count=0, s_axis_tready=0, all peaks=0, period counter=0.
- Reset mid-operation discards any pending snapshot, with no partial output.
- Input accept: a sample is taken when s_axis_tvalid & s_axis_tready.
  - If its channel ID < NUM_CH, that channel's peak becomes max(peak, tdata), using an unsigned compare. Equal values leave the peak unchanged.
  - If the channel ID is >= NUM_CH, the sample is dropped.
- Period counter: counts 0..PERIOD_CYCLES-1 every cycle, independent of traffic, and wraps to 0. The tick is the cycle where the count is PERIOD_CYCLES-1.
- Output slot: either EMPTY or FULL, and is FULL exactly when m_axis_tvalid=1.
  - The slot is treated as free on a tick if it is EMPTY, or if m_axis_tready=1 in that same cycle (handshake completing).
- Tick with slot free:
  - m_axis_tdata loads the snapshot and m_axis_tvalid is set to 1 on the next edge.
  - The snapshot includes a same-cycle accepted sample, i.e. the value loaded for that channel is max(peak, sample).
  - All peaks clear to 0 on the same edge.
  - Latency: the snapshot is visible one cycle after the tick.
- Tick with slot FULL and no handshake:
  - No snapshot is taken and the peaks keep accumulating (no clear), so the next successful snapshot covers multiple periods.
  - overrun_count increments, saturating at 16'hFFFF.
- Handshake without a tick: m_axis_tvalid drops to 0 on the next edge and m_axis_tdata holds its value.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tvalid must not change.
- No combinational path from m_axis_tready to any output; all outputs are registered.
- Internal state: two-state output FSM (EMPTY, FULL), period counter, NUM_CH peak registers, and the overrun counter.

Test Plan:
- PERIOD_CYCLES=16, m_axis_tready=1. Send ch0=0x0100, ch0=0x0080, ch5=0xABCD in period 1.
  - Required: exactly one snapshot, one cycle after the tick, with bits[15:0]=0x0100, bits[95:80]=0xABCD, all other bits 0.
  - The next snapshot is all zeros.
- Same setup, sample ch3=0x1234 accepted on the tick cycle.
  - Required: the snapshot carries 0x1234 in ch3.
  - The following period's snapshot has ch3=0.
- m_axis_tready held 0 for 3 full periods after the first snapshot, with ch1 samples 0x0010, 0x0020, 0x0030 spread across those periods.
  - Required: m_axis_tdata stays stable throughout and overrun_count=3.
  - After tready rises, the next snapshot has ch1=0x0030.
- m_axis_tready pulsed high exactly on a tick cycle while the slot is FULL.
  - Required: m_axis_tvalid stays 1, new data loads on the next edge, and overrun_count is unchanged.
- NUM_CH=8, send ch12=0xFFFF.
  - Required: the snapshot has bits[255:128]=0 and the sample has no effect.
- areset asserted for 1 cycle while the slot is FULL with accumulated peaks.
  - Required: the next cycle shows m_axis_tvalid=0, overrun_count=0, s_axis_tready=0 during reset, and the first post-reset snapshot is all zeros absent input.
